load_ext_ctrl: RTL and testbench

Sequencer for sub-word loads in the CPU memory stage. It accepts one load request from the pipeline, issues a word-aligned read to data memory, waits for the acknowledge, then selects the addressed byte, halfword or word and sign- or zero-extends it to 32 bits. It flags misaligned addresses, illegal load types and memory timeouts instead of returning data.

---
 rtl/load_ext_ctrl_if.sv | 36 +++
 rtl/load_ext_ctrl.sv | 164 ++++++++++++++++
 tb/tb_load_ext_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_ext_ctrl_if.sv
// ============================================================================
// Module      : load_ext_ctrl_if
// Description : Request, memory and response signals of the sub-word load
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_ext_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    // master is the environment: the pipeline together with data memory
    modport master (
        output req_valid, req_addr, req_type, mem_ack, mem_rdata, resp_ready,
        input  req_ready, mem_rd, mem_addr, resp_valid, resp_data, resp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_type, mem_ack, mem_rdata, resp_ready,
        output req_ready, mem_rd, mem_addr, resp_valid, resp_data, resp_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/load_ext_ctrl.sv
// ============================================================================
// Module      : load_ext_ctrl
// Description : Sub-word load sequencer: word read, lane select, sign/zero
//               extension, with misalignment, illegal-type and timeout errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_ext_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    load_ext_ctrl_if.slave  bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mem  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_addr;
    logic [2:0]       r_type;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_data;
    logic             r_err;

    logic             w_type_bad;
    logic             w_misaligned;
    logic             w_req_bad;
    logic             w_tmo;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;

    logic             w_req_ready;
    logic             w_mem_rd;
    logic [31:0]      w_mem_addr;
    logic             w_resp_valid;
    logic             w_busy;

    // Request classification on the live request inputs (used only in IDLE)
    always_comb begin
        w_type_bad = 1'b0;
        case (bus.req_type)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_type_bad = 1'b0;
            default:                                w_type_bad = 1'b1;
        endcase
        w_misaligned = ((bus.req_type[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_type[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        w_req_bad    = w_type_bad || w_misaligned;
    end

    // Last permitted wait cycle: the counter holds TIMEOUT-1 here with no ack
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == c_tmo_last);

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_ext  = bus.mem_rdata;
        case (r_type[1:0])
            2'b00:   w_ext = {{24{~r_type[2] & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_type[2] & w_half[15]}}, w_half};
            default: w_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.req_valid) begin
                    w_state_nxt = w_req_bad ? c_st_resp : c_st_mem;
                end
            end
            c_st_mem: begin
                if (bus.mem_ack || w_tmo) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                if (bus.resp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_req_ready  = (r_state == c_st_idle);
        w_mem_rd     = (r_state == c_st_mem);
        w_resp_valid = (r_state == c_st_resp);
        w_busy       = (r_state != c_st_idle);
        w_mem_addr   = '0;
        if (r_state == c_st_mem) begin
            w_mem_addr = {r_addr[31:2], 2'b00};
        end
    end

    // Datapath; ack takes priority over timeout in the final wait cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_type <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.req_valid) begin
                        r_addr <= bus.req_addr;
                        r_type <= bus.req_type;
                        r_cnt  <= '0;
                        r_data <= '0;
                        r_err  <= w_req_bad;
                    end
                end
                c_st_mem: begin
                    if (bus.mem_ack) begin
                        r_data <= w_ext;
                        r_err  <= 1'b0;
                    end else if (w_tmo) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.mem_rd     = w_mem_rd;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = r_data;
    assign bus.resp_err   = r_err;
    assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_load_ext_ctrl.sv
// ============================================================================
// Module      : tb_load_ext_ctrl
// Description : Directed self-checking bench for load_ext_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_ext_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    load_ext_ctrl_if bus ();

    load_ext_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, answers mem_rd with ack on its ack_at-th cycle
    // (0 = never), then accepts the response. data stays X if nothing returns.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] typ,
                            input logic [31:0] rdata, input int ack_at,
                            output logic [31:0] data, output logic err,
                            output logic [31:0] maddr, output int rd_cycles);
        data = 'x; err = 1'bx; maddr = '0; rd_cycles = 0;
        bus.req_addr  = addr;
        bus.req_type  = typ;
        bus.mem_rdata = rdata;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ack = 1'b0;
            if (bus.resp_valid) begin
                data = bus.resp_data;
                err  = bus.resp_err;
                break;
            end
            if (bus.mem_rd) begin
                rd_cycles++;
                maddr = bus.mem_addr;
                if (rd_cycles == ack_at) bus.mem_ack = 1'b1;
            end
            step();
        end
        bus.mem_ack    = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if ({bus.req_ready, bus.mem_rd, bus.resp_valid, bus.resp_err, bus.busy} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b expected 10000", {bus.req_ready, bus.mem_rd, bus.resp_valid, bus.resp_err, bus.busy}); else passes++;
        checks++; if ({bus.mem_addr, bus.resp_data} !== 64'h0)
            $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.resp_data}); else passes++;
        rst = 1'b0;
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checks++; if ({bus.req_ready, bus.mem_rd, bus.resp_valid, bus.busy} !== 4'b1000)
            $display("FAIL idle_ack_ignored: got %b expected 1000", {bus.req_ready, bus.mem_rd, bus.resp_valid, bus.busy}); else passes++;
    endtask

    task automatic test_lb_sign();
        logic [31:0] d, ma; logic e; int rc;
        run_load(32'h1003, 3'b000, 32'h80AA55CC, 1, d, e, ma, rc);
        checks++; if (ma !== 32'h1000) $display("FAIL lb_mem_addr: got %h expected 00001000", ma); else passes++;
        checks++; if ({e, d} !== {1'b0, 32'hFFFFFF80}) $display("FAIL lb_data: got err=%b data=%h expected err=0 data=ffffff80", e, d); else passes++;
        checks++; if (rc !== 1) $display("FAIL lb_rd_cycles: got %0d expected 1", rc); else passes++;
    endtask

    task automatic test_extend();
        logic [31:0] d, ma; logic e; int rc;
        run_load(32'h2002, 3'b100, 32'h80F17F00, 1, d, e, ma, rc);
        checks++; if ({e, d} !== {1'b0, 32'h000000F1}) $display("FAIL lbu: got err=%b data=%h expected err=0 data=000000f1", e, d); else passes++;
        run_load(32'h2002, 3'b101, 32'h80F17F00, 1, d, e, ma, rc);
        checks++; if ({e, d} !== {1'b0, 32'h000080F1}) $display("FAIL lhu: got err=%b data=%h expected err=0 data=000080f1", e, d); else passes++;
        run_load(32'h2000, 3'b001, 32'h1234FFFE, 1, d, e, ma, rc);
        checks++; if ({e, d} !== {1'b0, 32'hFFFFFFFE}) $display("FAIL lh_low: got err=%b data=%h expected err=0 data=fffffffe", e, d); else passes++;
        run_load(32'h2002, 3'b001, 32'h80F17F00, 1, d, e, ma, rc);
        checks++; if ({e, d} !== {1'b0, 32'hFFFF80F1}) $display("FAIL lh_high: got err=%b data=%h expected err=0 data=ffff80f1", e, d); else passes++;
        run_load(32'h2001, 3'b000, 32'h80F17F00, 1, d, e, ma, rc);
        checks++; if ({e, d} !== {1'b0, 32'h0000007F}) $display("FAIL lb_pos: got err=%b data=%h expected err=0 data=0000007f", e, d); else passes++;
        run_load(32'h2004, 3'b100, 32'h80F17F9C, 1, d, e, ma, rc);
        checks++; if ({e, d} !== {1'b0, 32'h0000009C}) $display("FAIL lbu_lane0: got err=%b data=%h expected err=0 data=0000009c", e, d); else passes++;
    endtask

    task automatic test_errors();
        logic [31:0] d, ma; logic e; int rc;
        logic [31:0] addrs [5] = '{32'h3002, 32'h3001, 32'h3000, 32'h3003, 32'h3000};
        logic [2:0]  types [5] = '{3'b010, 3'b001, 3'b011, 3'b101, 3'b111};
        for (int i = 0; i < 5; i++) begin
            run_load(addrs[i], types[i], 32'hFFFFFFFF, 1, d, e, ma, rc);
            checks++; if ({e, d, rc} !== {1'b1, 32'h0, 32'd0})
                $display("FAIL err_case%0d: got err=%b data=%h rd_cycles=%0d expected err=1 data=0 rd_cycles=0", i, e, d, rc); else passes++;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d, ma; logic e; int rc;
        run_load(32'h5000, 3'b010, 32'h11223344, 0, d, e, ma, rc);
        checks++; if ({e, d, rc} !== {1'b1, 32'h0, 32'd4})
            $display("FAIL timeout: got err=%b data=%h rd_cycles=%0d expected err=1 data=0 rd_cycles=4", e, d, rc); else passes++;
        run_load(32'h5000, 3'b010, 32'h11223344, 4, d, e, ma, rc);
        checks++; if ({e, d, rc} !== {1'b0, 32'h11223344, 32'd4})
            $display("FAIL ack_at_limit: got err=%b data=%h rd_cycles=%0d expected err=0 data=11223344 rd_cycles=4", e, d, rc); else passes++;
    endtask

    task automatic test_backpressure();
        bus.req_addr = 32'h6000; bus.req_type = 3'b010; bus.mem_rdata = 32'hCAFEF00D;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        // Activity on the other side must not disturb the held response
        bus.req_valid = 1'b1; bus.req_addr = 32'h6100; bus.mem_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_data} !== {3'b100, 32'hCAFEF00D})
                $display("FAIL backpressure%0d: got valid=%b ready=%b err=%b data=%h expected 1 0 0 cafef00d",
                         i, bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_data); else passes++;
            step();
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        checks++; if ({bus.busy, bus.req_ready} !== 2'b01) $display("FAIL bp_release: got busy/ready=%b expected 01", {bus.busy, bus.req_ready}); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_pat [6] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
        logic [2:0] got;
        bus.req_addr = 32'h8000; bus.req_type = 3'b010; bus.mem_rdata = 32'h0BADF00D;
        bus.req_valid = 1'b1; bus.mem_ack = 1'b1; bus.resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 5) begin
                bus.req_valid = 1'b0; bus.mem_ack = 1'b0; bus.resp_ready = 1'b0;
            end
            got = {bus.req_ready, bus.mem_rd, bus.resp_valid};
            checks++; if (got !== exp_pat[i]) $display("FAIL b2b_cycle%0d: got ready/rd/valid=%b expected %b", i, got, exp_pat[i]); else passes++;
            if (got[0]) begin
                checks++; if (bus.resp_data !== 32'h0BADF00D) $display("FAIL b2b_data%0d: got %h expected 0badf00d", i, bus.resp_data); else passes++;
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, ma; logic e; int rc;
        bus.req_addr = 32'h7000; bus.req_type = 3'b010; bus.mem_rdata = 32'h12345678;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_rd !== 1'b1) $display("FAIL mid_in_mem: got mem_rd=%b expected 1", bus.mem_rd); else passes++;
        #1 rst = 1'b1;
        #1;
        checks++; if ({bus.mem_rd, bus.busy, bus.req_ready, bus.mem_addr} !== {3'b001, 32'h0})
            $display("FAIL mid_async_mem: got rd/busy/ready=%b addr=%h expected 001 addr=0", {bus.mem_rd, bus.busy, bus.req_ready}, bus.mem_addr); else passes++;
        bus.mem_ack = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if ({bus.resp_valid, bus.busy, bus.mem_rd} !== 3'b000)
            $display("FAIL mid_ack_ignored: got valid/busy/rd=%b expected 000", {bus.resp_valid, bus.busy, bus.mem_rd}); else passes++;
        bus.mem_ack = 1'b0;
        run_load(32'h4000, 3'b010, 32'hDEADBEEF, 1, d, e, ma, rc);
        checks++; if ({e, d, ma} !== {1'b0, 32'hDEADBEEF, 32'h4000})
            $display("FAIL post_reset_lw: got err=%b data=%h addr=%h expected err=0 data=deadbeef addr=00004000", e, d, ma); else passes++;

        // Reset while a response is waiting
        bus.req_addr = 32'h4004; bus.req_type = 3'b010; bus.mem_rdata = 32'hA5A5A5A5;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1) $display("FAIL mid_in_resp: got resp_valid=%b expected 1", bus.resp_valid); else passes++;
        #1 rst = 1'b1;
        #1;
        checks++; if ({bus.resp_valid, bus.resp_data} !== {1'b0, 32'h0})
            $display("FAIL mid_async_resp: got valid=%b data=%h expected 0 00000000", bus.resp_valid, bus.resp_data); else passes++;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_type = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.resp_ready = 1'b0;
        test_reset();
        test_lb_sign();
        test_extend();
        test_errors();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
